// File: rtl/stb_req_queue.sv
// stb_req_queue: counts incoming event requests and issues them one at a time
// as single-cycle strobes toward a strobe CDC stage. After each strobe there
// are at least GUARD_CYCLES idle cycles, so the far side can settle.
//
// Optional feature (macro STB_REQ_ACK_EN): GUARD also waits for a completion
// pulse on ack_i before the next strobe may be issued.
//
// Ports:
//   stb_i_clk   source-domain clock, rising edge
//   lock_rst    asynchronous active-high reset
//   req_i       one request per cycle held high
//   ack_i       synchronised completion pulse (only used with STB_REQ_ACK_EN)
//   stb_o       registered one-cycle strobe, high while in ISSUE
//   pending_o   requests accepted but not yet issued (saturating)
//   overflow_o  sticky flag, set when a request is dropped at full
//   busy_o      high whenever the FSM is not IDLE
module stb_req_queue #(
    parameter int unsigned CNT_WIDTH    = 4,
    parameter int unsigned GUARD_CYCLES = 8
) (
    input  logic                 stb_i_clk,
    input  logic                 lock_rst,
    input  logic                 req_i,
    input  logic                 ack_i,
    output logic                 stb_o,
    output logic [CNT_WIDTH-1:0] pending_o,
    output logic                 overflow_o,
    output logic                 busy_o
);

    localparam int unsigned GW = 8;
    localparam logic [CNT_WIDTH-1:0] CNT_FULL   = {CNT_WIDTH{1'b1}};
    localparam logic [GW-1:0]        GUARD_LOAD = GW'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t               state_q,    state_d;
    logic [CNT_WIDTH-1:0] pending_q,  pending_d;
    logic                 overflow_q, overflow_d;
    logic [GW-1:0]        guard_q,    guard_d;
    logic                 stb_q,      stb_d;
    logic                 busy_q,     busy_d;

    logic issue_dec_c;
    logic full_c;
    logic accept_c;
    logic guard_exit_c;

`ifdef STB_REQ_ACK_EN
    logic ack_flag_q, ack_flag_d;
`else
    logic unused_ack;
    assign unused_ack = ack_i;
`endif

    // Next-state, counter and output computation
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        overflow_d   = overflow_q;
        guard_d      = guard_q;
        issue_dec_c  = (state_q == ISSUE);
        full_c       = (pending_q == CNT_FULL);
        // At full a request still fits if the ISSUE decrement frees a slot
        accept_c     = req_i && (!full_c || issue_dec_c);
`ifdef STB_REQ_ACK_EN
        ack_flag_d   = ack_flag_q;
        // An ack arriving on the final GUARD cycle releases it immediately
        guard_exit_c = ack_flag_q || ack_i;
`else
        guard_exit_c = 1'b1;
`endif

        if (accept_c && !issue_dec_c) begin
            pending_d = pending_q + CNT_WIDTH'(1);
        end else if (!accept_c && issue_dec_c) begin
            pending_d = pending_q - CNT_WIDTH'(1);
        end

        if (req_i && !accept_c) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pending_q != '0) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = GUARD;
                guard_d = GUARD_LOAD;
            end
            GUARD: begin
                if (guard_q == '0) begin
                    if (guard_exit_c) begin
                        state_d = IDLE;
                    end
                end else begin
                    guard_d = guard_q - GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                guard_d = '0;
            end
        endcase

`ifdef STB_REQ_ACK_EN
        if (ack_i && (state_q == ISSUE || state_q == GUARD)) begin
            ack_flag_d = 1'b1;
        end
        if (state_d == IDLE) begin
            ack_flag_d = 1'b0;
        end
`endif

        stb_d  = (state_d == ISSUE);
        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge stb_i_clk or posedge lock_rst) begin
        if (lock_rst) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            guard_q    <= '0;
            stb_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            guard_q    <= guard_d;
            stb_q      <= stb_d;
            busy_q     <= busy_d;
        end
    end

`ifdef STB_REQ_ACK_EN
    // Completion flag, cleared whenever the FSM returns to IDLE
    always_ff @(posedge stb_i_clk or posedge lock_rst) begin
        if (lock_rst) begin
            ack_flag_q <= 1'b0;
        end else begin
            ack_flag_q <= ack_flag_d;
        end
    end
`endif

    assign stb_o      = stb_q;
    assign pending_o  = pending_q;
    assign overflow_o = overflow_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_stb_req_queue.sv
// Directed bench for stb_req_queue (CNT_WIDTH=4, GUARD_CYCLES=8).
module tb_stb_req_queue;

    logic       clk;
    logic       lock_rst;
    logic       req_i;
    logic       ack_i;
    logic       stb_o;
    logic [3:0] pending_o;
    logic       overflow_o;
    logic       busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Strobe monitor: pulse count and spacing errors (spacing must be 10)
    int cyc = 0;
    int last_cyc = 0;
    bit last_valid = 1'b0;
    int stb_count = 0;
    int spacing_bad = 0;

    typedef struct {
        logic       req;
        logic       rst;
        logic       stb;
        logic [3:0] pend;
        logic       busy;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];

    stb_req_queue #(
        .CNT_WIDTH   (4),
        .GUARD_CYCLES(8)
    ) dut (
        .stb_i_clk (clk),
        .lock_rst  (lock_rst),
        .req_i     (req_i),
        .ack_i     (ack_i),
        .stb_o     (stb_o),
        .pending_o (pending_o),
        .overflow_o(overflow_o),
        .busy_o    (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (lock_rst) begin
            last_valid <= 1'b0;
        end else if (stb_o) begin
            stb_count <= stb_count + 1;
            if (last_valid && (cyc - last_cyc) != 10) spacing_bad <= spacing_bad + 1;
            last_cyc   <= cyc;
            last_valid <= 1'b1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic rs, input logic s,
                       input logic [3:0] p, input logic b, input logic o);
        vec_t v;
        v.req = r; v.rst = rs; v.stb = s; v.pend = p; v.busy = b; v.ovf = o;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        lock_rst = 1'b1;
        req_i    = 1'b0;
        ack_i    = 1'b0;
        step();
        step();
        lock_rst = 1'b0;
        step();
    endtask

    initial begin
        int base_cnt;
        int base_sp;
        int max_p;
        lock_rst = 1'b1;
        req_i    = 1'b0;
        ack_i    = 1'b0;

        // Single request, then a request coinciding with the ISSUE cycle
        add(0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0);
        add(0, 0, 1, 1, 1, 0);
        add(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 7; i++) add(0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0);
        add(0, 0, 1, 1, 1, 0);
        add(1, 0, 0, 1, 1, 0);
        for (int i = 0; i < 7; i++) add(0, 0, 0, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 1, 1, 0);
        add(0, 0, 0, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            req_i    = vecs[i].req;
            lock_rst = vecs[i].rst;
            step();
            if (stb_o !== vecs[i].stb || pending_o !== vecs[i].pend ||
                busy_o !== vecs[i].busy || overflow_o !== vecs[i].ovf) begin
                n_cmp++;
                n_bad++;
                $display("FAIL vec%0d: got stb=%b pend=%0d busy=%b ovf=%b expected stb=%b pend=%0d busy=%b ovf=%b",
                         i, stb_o, pending_o, busy_o, overflow_o,
                         vecs[i].stb, vecs[i].pend, vecs[i].busy, vecs[i].ovf);
            end else begin
                n_cmp++;
            end
        end
        req_i = 1'b0;

        // Burst of 5 requests
        do_reset();
        base_cnt = stb_count;
        base_sp  = spacing_bad;
        max_p    = 0;
        req_i    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (int'(pending_o) > max_p) max_p = int'(pending_o);
        end
        req_i = 1'b0;
        for (int i = 0; i < 60; i++) step();
        chk("burst_pulses", stb_count - base_cnt, 5);
        chk("burst_spacing", spacing_bad - base_sp, 0);
        chk("burst_peak", max_p, 4);
        chk("burst_end_pending", int'(pending_o), 0);
        chk("burst_end_busy", int'(busy_o), 0);

        // Overflow: 20 consecutive requests, 3 dropped
        do_reset();
        base_cnt = stb_count;
        base_sp  = spacing_bad;
        max_p    = 0;
        req_i    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (int'(pending_o) > max_p) max_p = int'(pending_o);
            if (i == 16) chk("ovf_full_edge17", int'(pending_o), 15);
            if (i == 16) chk("ovf_not_yet", int'(overflow_o), 0);
        end
        req_i = 1'b0;
        chk("ovf_set", int'(overflow_o), 1);
        chk("ovf_peak", max_p, 15);
        for (int i = 0; i < 200; i++) step();
        chk("ovf_sticky", int'(overflow_o), 1);
        chk("ovf_pulses", stb_count - base_cnt, 17);
        chk("ovf_spacing", spacing_bad - base_sp, 0);
        chk("ovf_end_pending", int'(pending_o), 0);

        // Request during ISSUE with pending=3 keeps pending at 3
        do_reset();
        req_i = 1'b1;
        for (int i = 0; i < 4; i++) step();
        req_i = 1'b0;
        chk("sim_pend_pre", int'(pending_o), 3);
        for (int i = 0; i < 8; i++) step();
        chk("sim_issue_stb", int'(stb_o), 1);
        chk("sim_issue_pend", int'(pending_o), 3);
        req_i = 1'b1;
        step();
        req_i = 1'b0;
        chk("sim_after_pend", int'(pending_o), 3);
        chk("sim_after_stb", int'(stb_o), 0);

        // Reset mid-burst during GUARD with pending=6
        do_reset();
        req_i = 1'b1;
        for (int i = 0; i < 7; i++) step();
        req_i = 1'b0;
        chk("rst_pre_pend", int'(pending_o), 6);
        chk("rst_pre_busy", int'(busy_o), 1);
        lock_rst = 1'b1;
        #1;
        chk("rst_async_outs", {stb_o, pending_o, overflow_o, busy_o}, 0);
        step();
        chk("rst_hold_outs", {stb_o, pending_o, overflow_o, busy_o}, 0);
        step();
        lock_rst = 1'b0;
        base_cnt = stb_count;
        for (int i = 0; i < 30; i++) step();
        chk("rst_no_stb", stb_count - base_cnt, 0);
        chk("rst_idle_busy", int'(busy_o), 0);
        req_i = 1'b1;
        step();
        req_i = 1'b0;
        chk("rst_new_pend", int'(pending_o), 1);
        chk("rst_new_stb0", int'(stb_o), 0);
        step();
        chk("rst_new_stb1", int'(stb_o), 1);

        // Reset asserted while the strobe is high drops it at once
        lock_rst = 1'b1;
        #1;
        chk("rst_issue_stb", int'(stb_o), 0);
        step();
        lock_rst = 1'b0;
        step();
        chk("rst_issue_pend", int'(pending_o), 0);
        chk("rst_issue_busy", int'(busy_o), 0);

`ifdef STB_REQ_ACK_EN
        // Ack mode: GUARD holds until ack_i arrives
        do_reset();
        base_cnt = stb_count;
        req_i = 1'b1;
        step();
        step();
        req_i = 1'b0;
        step();
        for (int i = 0; i < 40; i++) step();
        chk("ack_wait_busy", int'(busy_o), 1);
        chk("ack_wait_stb", stb_count - base_cnt, 1);
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        chk("ack_idle", int'(busy_o), 0);
        step();
        chk("ack_next_stb", int'(stb_o), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
